// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle_multiciclo
// Purpose  : Multicycle (IDLE/DECODE/EXEC/WB) control unit for the
//            ProcessadorFinal datapath; one instruction per four cycles.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo #(
    parameter int         IMM_W     = 14,
    parameter logic [3:0] ALUOP_ADD = 4'b0010,
    parameter logic [3:0] ALUOP_SUB = 4'b0110
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        Zero,
    output logic [5:0]  RS,
    output logic [5:0]  RT,
    output logic [5:0]  RD,
    output logic [31:0] imediato,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        ULAData,
    output logic        SumZero,
    output logic        RegWrite,
    output logic        NOP,
    output logic        StackOP,
    output logic        JAL,
    output logic        branch_taken,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h01;
    localparam logic [5:0] c_OP_LI    = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_PUSH  = 6'h05;
    localparam logic [5:0] c_OP_POP   = 6'h06;
    localparam logic [5:0] c_OP_NOP   = 6'h3F;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr;

    logic [5:0]  w_rd;
    logic [31:0] w_imm;
    logic [3:0]  w_aluop;
    logic        w_alusrc;
    logic        w_uladata;
    logic        w_sumzero;
    logic        w_nop;
    logic        w_stackop;
    logic        w_jal;
    logic        w_regwrite;
    logic        w_beq;
    logic        w_illegal;

    assign instr_ready = (r_state == S_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (instr_valid) w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = S_WB;
            S_WB:     w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Decode works from the latched word so instr may change after acceptance.
    always_comb begin
        w_rd       = 6'd0;
        w_imm      = {{(32-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};
        w_aluop    = 4'd0;
        w_alusrc   = 1'b0;
        w_uladata  = 1'b0;
        w_sumzero  = 1'b0;
        w_nop      = 1'b0;
        w_stackop  = 1'b0;
        w_jal      = 1'b0;
        w_regwrite = 1'b0;
        w_beq      = 1'b0;
        w_illegal  = 1'b0;
        case (r_instr[31:26])
            c_OP_RTYPE: begin
                w_aluop    = r_instr[3:0];
                w_rd       = r_instr[13:8];
                w_regwrite = 1'b1;
            end
            c_OP_ADDI: begin
                w_alusrc   = 1'b1;
                w_aluop    = ALUOP_ADD;
                w_rd       = r_instr[19:14];
                w_regwrite = 1'b1;
            end
            c_OP_LI: begin
                w_sumzero  = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = ALUOP_ADD;
                w_rd       = r_instr[19:14];
                w_regwrite = 1'b1;
            end
            c_OP_JAL: begin
                w_jal      = 1'b1;
                w_rd       = 6'd63;
                w_regwrite = 1'b1;
            end
            c_OP_BEQ: begin
                w_aluop = ALUOP_SUB;
                w_beq   = 1'b1;
            end
            c_OP_PUSH: begin
                w_stackop = 1'b1;
                w_uladata = 1'b1;
                w_alusrc  = 1'b1;
                w_imm     = 32'hFFFF_FFFF;
                w_aluop   = ALUOP_ADD;
            end
            c_OP_POP: begin
                w_stackop  = 1'b1;
                w_uladata  = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = 32'd1;
                w_aluop    = ALUOP_ADD;
                w_rd       = r_instr[19:14];
                w_regwrite = 1'b1;
            end
            c_OP_NOP: w_nop = 1'b1;
            default: begin
                w_nop     = 1'b1;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_instr      <= 32'd0;
            RS           <= 6'd0;
            RT           <= 6'd0;
            RD           <= 6'd0;
            imediato     <= 32'd0;
            ALUOp        <= 4'd0;
            ALUSrc       <= 1'b0;
            ULAData      <= 1'b0;
            SumZero      <= 1'b0;
            RegWrite     <= 1'b0;
            NOP          <= 1'b0;
            StackOP      <= 1'b0;
            JAL          <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: if (instr_valid) r_instr <= instr;
                S_DECODE: begin
                    RS       <= r_instr[25:20];
                    RT       <= r_instr[19:14];
                    RD       <= w_rd;
                    imediato <= w_imm;
                    ALUOp    <= w_aluop;
                    ALUSrc   <= w_alusrc;
                    ULAData  <= w_uladata;
                    SumZero  <= w_sumzero;
                    NOP      <= w_nop;
                    StackOP  <= w_stackop;
                    JAL      <= w_jal;
                end
                S_EXEC: begin
                    RegWrite     <= w_regwrite;
                    branch_taken <= w_beq & Zero;
                    illegal      <= w_illegal;
                end
                S_WB: begin
                    RS           <= 6'd0;
                    RT           <= 6'd0;
                    RD           <= 6'd0;
                    imediato     <= 32'd0;
                    ALUOp        <= 4'd0;
                    ALUSrc       <= 1'b0;
                    ULAData      <= 1'b0;
                    SumZero      <= 1'b0;
                    RegWrite     <= 1'b0;
                    NOP          <= 1'b0;
                    StackOP      <= 1'b0;
                    JAL          <= 1'b0;
                    branch_taken <= 1'b0;
                    illegal      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_controle_multiciclo
// Purpose  : Scoreboard bench: stimulus queues the expected WB-cycle controls,
//            a monitor follows each accepted instruction through its sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        Zero;
    logic [5:0]  RS, RT, RD;
    logic [31:0] imediato;
    logic [3:0]  ALUOp;
    logic        ALUSrc, ULAData, SumZero, RegWrite, NOP, StackOP, JAL;
    logic        branch_taken, illegal;

    unidade_controle_multiciclo dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Zero(Zero), .RS(RS), .RT(RT), .RD(RD),
        .imediato(imediato), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ULAData(ULAData),
        .SumZero(SumZero), .RegWrite(RegWrite), .NOP(NOP), .StackOP(StackOP),
        .JAL(JAL), .branch_taken(branch_taken), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // flag order: ALUSrc ULAData SumZero NOP StackOP JAL RegWrite branch_taken illegal
    localparam logic [8:0] c_F_NONE = 9'b000000000;
    localparam logic [8:0] c_F_R    = 9'b000000100;
    localparam logic [8:0] c_F_ADDI = 9'b100000100;
    localparam logic [8:0] c_F_LI   = 9'b101000100;
    localparam logic [8:0] c_F_JAL  = 9'b000001100;
    localparam logic [8:0] c_F_PUSH = 9'b110010000;
    localparam logic [8:0] c_F_POP  = 9'b110010100;
    localparam logic [8:0] c_F_NOP  = 9'b000100000;
    localparam logic [8:0] c_F_BT   = 9'b000000010;
    localparam logic [8:0] c_F_ILL  = 9'b000100001;
    localparam logic [62:0] c_WB_MASK = 63'h7;

    logic [62:0] obs;
    assign obs = {RS, RT, RD, imediato, ALUOp, ALUSrc, ULAData, SumZero, NOP,
                  StackOP, JAL, RegWrite, branch_taken, illegal};

    int          checks   = 0;
    int          failures = 0;
    int          edge_cnt = 0;
    logic [62:0] exp_q[$];

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    function automatic logic [62:0] mk(input logic [5:0] rs, input logic [5:0] rt,
                                       input logic [5:0] rd, input logic [31:0] im,
                                       input logic [3:0] op, input logic [8:0] f);
        return {rs, rt, rd, im, op, f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] ins, input logic [62:0] e,
                         input bit keep, output int t);
        int n;
        instr       = ins;
        instr_valid = 1'b1;
        exp_q.push_back(e);
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: instr %h not accepted within 20 cycles", ins);
            instr_valid = 1'b0;
            t = -1;
        end else begin
            @(posedge clock);
            #1 t = edge_cnt;
            @(negedge clock);
            if (!keep) instr_valid = 1'b0;
        end
    endtask

    // Monitor: k tracks position in the sequence of the instruction in flight.
    initial begin
        int          k;
        logic        prev_ready;
        logic [62:0] e;
        k = 0;
        prev_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                if ((k == 2 || k == 3) && exp_q.size() > 0) void'(exp_q.pop_front());
                k = 0;
            end else begin
                case (k)
                    0: if (prev_ready && !instr_ready) begin
                        chk("decode_ctrl_zero", {1'b0, obs}, 64'd0);
                        k = 2;
                    end
                    2: begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_accept: got accept, expected none queued");
                            k = 0;
                        end else begin
                            chk("exec_ctrl", {1'b0, obs}, {1'b0, exp_q[0] & ~c_WB_MASK});
                            k = 3;
                        end
                    end
                    3: begin
                        e = exp_q.pop_front();
                        chk("wb_ctrl", {1'b0, obs}, {1'b0, e});
                        k = 4;
                    end
                    default: begin
                        chk("idle_after_wb", {obs, instr_ready}, {63'd0, 1'b1});
                        k = 0;
                    end
                endcase
            end
            prev_ready = instr_ready;
        end
    end

    initial begin
        int t0, t1, t2;
        reset       = 1'b1;
        instr       = 32'd0;
        instr_valid = 1'b0;
        Zero        = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_state", {obs, instr_ready}, {63'd0, 1'b1});
        reset = 1'b0;
        @(negedge clock);

        issue({6'h02, 6'd0, 6'd3, 14'd10}, mk(0, 3, 3, 32'd10, 4'b0010, c_F_LI), 0, t0);
        issue({6'h02, 6'd0, 6'd4, 14'd20}, mk(0, 4, 4, 32'd20, 4'b0010, c_F_LI), 0, t0);
        issue({6'h00, 6'd3, 6'd4, 6'd5, 4'd0, 4'b0010},
              mk(3, 4, 5, 32'h502, 4'b0010, c_F_R), 0, t0);
        issue({6'h01, 6'd3, 6'd6, 14'd5}, mk(3, 6, 6, 32'd5, 4'b0010, c_F_ADDI), 0, t0);
        issue({6'h01, 6'd3, 6'd6, 14'h3FFF},
              mk(3, 6, 6, 32'hFFFF_FFFF, 4'b0010, c_F_ADDI), 0, t0);
        issue({6'h02, 6'd0, 6'd7, 14'h2000},
              mk(0, 7, 7, 32'hFFFF_E000, 4'b0010, c_F_LI), 0, t0);
        issue({6'h03, 6'd1, 6'd2, 14'h0100}, mk(1, 2, 63, 32'h100, 4'b0000, c_F_JAL), 0, t0);
        issue({6'h05, 6'd62, 6'd9, 14'h0005},
              mk(62, 9, 0, 32'hFFFF_FFFF, 4'b0010, c_F_PUSH), 0, t0);
        issue({6'h06, 6'd62, 6'd9, 14'h0000}, mk(62, 9, 9, 32'd1, 4'b0010, c_F_POP), 0, t0);
        issue({6'h3F, 6'd0, 6'd0, 14'h0000}, mk(0, 0, 0, 32'd0, 4'b0000, c_F_NOP), 0, t0);
        issue({6'h00, 6'd1, 6'd2, 6'd0, 4'd0, 4'b0110},
              mk(1, 2, 0, 32'd6, 4'b0110, c_F_R), 0, t0);
        Zero = 1'b0;
        issue({6'h04, 6'd3, 6'd4, 14'd0}, mk(3, 4, 0, 32'd0, 4'b0110, c_F_NONE), 0, t0);

        // Abort an LI while in EXEC: no write may follow.
        issue({6'h02, 6'd0, 6'd8, 14'd1}, mk(0, 8, 8, 32'd1, 4'b0010, c_F_LI), 0, t0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("reset_mid_seq", {obs, instr_ready}, {63'd0, 1'b1});
        begin
            logic any_wr;
            any_wr = 1'b0;
            repeat (4) begin
                @(negedge clock);
                any_wr = any_wr | RegWrite;
            end
            chk("no_write_after_abort", {63'd0, any_wr}, 64'd0);
        end

        // Back-to-back with instr_valid held high.
        Zero = 1'b1;
        issue({6'h01, 6'd3, 6'd6, 14'd5}, mk(3, 6, 6, 32'd5, 4'b0010, c_F_ADDI), 1, t0);
        issue({6'h04, 6'd3, 6'd3, 14'd0}, mk(3, 3, 0, 32'd0, 4'b0110, c_F_BT), 1, t1);
        issue({6'h2A, 6'd1, 6'd2, 14'h0003}, mk(1, 2, 0, 32'd3, 4'b0000, c_F_ILL), 1, t2);
        chk("accept_spacing_1", 64'(t1 - t0), 64'd4);
        chk("accept_spacing_2", 64'(t2 - t1), 64'd4);
        instr_valid = 1'b0;

        repeat (10) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
